agc_dc_blocker: RTL and testbench

AGC_DC_BLOCKER -- requirements
Module: agc_dc_blocker

---
 rtl/agc_dc_blocker.sv | 131 +++++++++++++
 tb/tb_agc_dc_blocker.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/agc_dc_blocker.sv
// Frame-averaging DC estimator and subtractor placed ahead of the AGC input stage.
// Optional macro DC_BLOCK_SAT_EN: saturate the corrected sample instead of wrapping it.
module agc_dc_blocker #(
    parameter int FRAME_LOG2 = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_enable,
    input  logic signed [7:0] In1,
    input  logic              reset_not,
    input  logic              dc_en,
    output logic signed [7:0] Out,
    output logic              ce_out,
    output logic signed [7:0] dc_est,
    output logic              frame_tick
);

    localparam int ACC_W = 8 + FRAME_LOG2;
    localparam logic [FRAME_LOG2-1:0] LAST_SLOT = {FRAME_LOG2{1'b1}};

    function automatic logic signed [7:0] sat9(input logic signed [8:0] d);
        logic signed [7:0] r;
        if (d > 9'sd127) begin
            r = 8'sh7F;
        end else if (d < -9'sd128) begin
            r = 8'sh80;
        end else begin
            r = d[7:0];
        end
        return r;
    endfunction

    logic        [FRAME_LOG2-1:0] r_cnt;
    logic signed [ACC_W-1:0]      r_acc;
    logic signed [7:0]            r_dc_est;
    logic signed [7:0]            r_out;
    logic                         r_ce;
    logic                         r_tick;

    logic signed [ACC_W-1:0]      w_in_ext;
    logic signed [ACC_W-1:0]      w_sum;
    logic signed [7:0]            w_new_est;
    logic                         w_last_slot;
    logic                         w_frame_done;
    logic signed [7:0]            w_corr;
    logic signed [7:0]            w_out_next;

    assign w_in_ext     = {{FRAME_LOG2{In1[7]}}, In1};
    assign w_sum        = r_acc + w_in_ext;
    // Mean of 2^FRAME_LOG2 8-bit samples always fits back into 8 bits.
    assign w_new_est    = 8'(w_sum >>> FRAME_LOG2);
    assign w_last_slot  = (r_cnt == LAST_SLOT);
    assign w_frame_done = clk_enable & reset_not & w_last_slot;

`ifdef DC_BLOCK_SAT_EN
    logic signed [8:0] w_diff;
    assign w_diff = {In1[7], In1} - {r_dc_est[7], r_dc_est};
    assign w_corr = sat9(w_diff);
`else
    // Low byte of the 9-bit difference equals the 8-bit modular difference.
    assign w_corr = In1 - r_dc_est;
`endif

    // Select corrected or raw sample for the output register.
    always_comb begin
        w_out_next = In1;
        if (dc_en) begin
            w_out_next = w_corr;
        end else begin
            w_out_next = In1;
        end
    end

    // Sample counter and frame accumulator; frame clear wins over frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (clk_enable) begin
            if (!reset_not) begin
                r_cnt <= '0;
                r_acc <= '0;
            end else if (w_last_slot) begin
                r_cnt <= '0;
                r_acc <= '0;
            end else begin
                r_cnt <= r_cnt + FRAME_LOG2'(1);
                r_acc <= w_sum;
            end
        end else begin
            r_cnt <= r_cnt;
            r_acc <= r_acc;
        end
    end

    // DC estimate register and the frame-complete pulse that follows it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dc_est <= 8'sd0;
            r_tick   <= 1'b0;
        end else begin
            r_tick <= w_frame_done;
            if (w_frame_done) begin
                r_dc_est <= w_new_est;
            end else begin
                r_dc_est <= r_dc_est;
            end
        end
    end

    // Output sample register holds between strobes; valid mirrors the strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= 8'sd0;
            r_ce  <= 1'b0;
        end else begin
            r_ce <= clk_enable;
            if (clk_enable) begin
                r_out <= w_out_next;
            end else begin
                r_out <= r_out;
            end
        end
    end

    assign Out        = r_out;
    assign ce_out     = r_ce;
    assign dc_est     = r_dc_est;
    assign frame_tick = r_tick;

endmodule

// File: tb/tb_agc_dc_blocker.sv
// Self-checking bench for agc_dc_blocker (FRAME_LOG2=2): directed scenarios plus
// randomized traffic compared every cycle against a frame-average reference model.
module tb_agc_dc_blocker;

    localparam int FL2 = 2;
    localparam int N   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clk_enable = 1'b1;
    logic signed [7:0] In1 = 8'sd55;
    logic              reset_not = 1'b1;
    logic              dc_en = 1'b1;
    logic signed [7:0] Out;
    logic              ce_out;
    logic signed [7:0] dc_est;
    logic              frame_tick;

    agc_dc_blocker #(.FRAME_LOG2(FL2)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_enable (clk_enable),
        .In1        (In1),
        .reset_not  (reset_not),
        .dc_en      (dc_en),
        .Out        (Out),
        .ce_out     (ce_out),
        .dc_est     (dc_est),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    // Reference model: list of samples in the current frame plus expected outputs.
    int m_q[$];
    int m_est  = 0;
    int m_out  = 0;
    int m_ce   = 0;
    int m_tick = 0;

    function automatic int floor_div(input int s);
        if (s >= 0) return s / N;
        return -((-s + N - 1) / N);
    endfunction

    function automatic int correct(input int d);
`ifdef DC_BLOCK_SAT_EN
        if (d > 127) return 127;
        if (d < -128) return -128;
        return d;
`else
        int w;
        w = (d + 512) % 256;
        if (w > 127) w = w - 256;
        return w;
`endif
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_est  = 0;
        m_out  = 0;
        m_ce   = 0;
        m_tick = 0;
    endtask

    task automatic model_step(input int x, input bit en, input bit rn, input bit de);
        int s;
        m_tick = 0;
        m_ce   = en ? 1 : 0;
        if (en) begin
            m_out = de ? correct(x - m_est) : x;
            if (!rn) begin
                m_q.delete();
            end else begin
                m_q.push_back(x);
                if (m_q.size() == N) begin
                    s = 0;
                    foreach (m_q[i]) s += m_q[i];
                    m_est  = floor_div(s);
                    m_tick = 1;
                    m_q.delete();
                end
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("model_out",  int'(Out),        m_out);
            check("model_ce",   int'(ce_out),     m_ce);
            check("model_est",  int'(dc_est),     m_est);
            check("model_tick", int'(frame_tick), m_tick);
        end
    end

    task automatic step(input bit en, input int x, input bit rn, input bit de);
        clk_enable = en;
        In1        = x[7:0];
        reset_not  = rn;
        dc_en      = de;
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(x, en, rn, de);
        @(negedge clk);
        #1;
    endtask

    initial begin
        int x;
        int off;
        model_reset();
        chk_on = 1'b1;
        @(negedge clk);
        #1;

        // Reset holds everything at zero despite active strobe and input.
        for (int i = 0; i < 3; i++) step(1'b1, 55, 1'b1, 1'b1);
        check("rst_out", int'(Out), 0);
        check("rst_ce", int'(ce_out), 0);
        check("rst_est", int'(dc_est), 0);
        check("rst_tick", int'(frame_tick), 0);
        rst = 1'b0;

        // Constant 20: passes until the first estimate, then cancels to 0.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 20, 1'b1, 1'b1);
            check("c20_out", int'(Out), (i < 4) ? 20 : 0);
            if (i == 3) check("c20_tick", int'(frame_tick), 1);
        end
        check("c20_est", int'(dc_est), 20);
        check("c20_model_est", m_est, 20);

        // Floor rounding of a negative mean.
        step(1'b1, -1, 1'b1, 1'b1);
        step(1'b1, -1, 1'b1, 1'b1);
        step(1'b1, -1, 1'b1, 1'b1);
        step(1'b1, -2, 1'b1, 1'b1);
        check("floor_est", int'(dc_est), -2);
        check("floor_model_est", m_est, -2);

        // Large positive difference: saturate or wrap.
        for (int i = 0; i < 4; i++) step(1'b1, -100, 1'b1, 1'b1);
        check("big_est", int'(dc_est), -100);
        step(1'b1, 100, 1'b1, 1'b1);
`ifdef DC_BLOCK_SAT_EN
        check("big_out", int'(Out), 127);
`else
        check("big_out", int'(Out), -56);
`endif

        // Realign the frame and bring the estimate back to 0.
        step(1'b1, 0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 0, 1'b1, 1'b1);
        check("zero_est", int'(dc_est), 0);

        // Strobe gaps: output holds, counter advances only on enabled samples.
        step(1'b1, 7, 1'b1, 1'b1);
        check("gap_out0", int'(Out), 7);
        check("gap_ce0", int'(ce_out), 1);
        step(1'b0, 9, 1'b1, 1'b1);
        check("gap_out1", int'(Out), 7);
        check("gap_ce1", int'(ce_out), 0);
        step(1'b0, 9, 1'b1, 1'b1);
        check("gap_out2", int'(Out), 7);
        step(1'b1, 3, 1'b1, 1'b1);
        check("gap_out3", int'(Out), 3);
        check("gap_ce3", int'(ce_out), 1);
        step(1'b1, 0, 1'b1, 1'b1);
        check("gap_tick_early", int'(frame_tick), 0);
        step(1'b1, 0, 1'b1, 1'b1);
        check("gap_tick", int'(frame_tick), 1);
        check("gap_est", int'(dc_est), 2);

        // Frame clear mid-frame: no tick at the old boundary, estimate retained.
        for (int i = 0; i < 4; i++) step(1'b1, 20, 1'b1, 1'b1);
        check("fc_est20", int'(dc_est), 20);
        step(1'b1, 60, 1'b1, 1'b1);
        step(1'b1, 60, 1'b1, 1'b1);
        step(1'b1, 60, 1'b0, 1'b1);
        check("fc_out", int'(Out), 40);
        step(1'b1, 60, 1'b1, 1'b1);
        check("fc_no_tick", int'(frame_tick), 0);
        check("fc_hold_est", int'(dc_est), 20);
        step(1'b1, 60, 1'b1, 1'b1);
        step(1'b1, 60, 1'b1, 1'b1);
        step(1'b1, 60, 1'b1, 1'b1);
        check("fc_tick", int'(frame_tick), 1);
        check("fc_est60", int'(dc_est), 60);

        // Randomized traffic around three DC offsets, with occasional resets.
        for (int p = 0; p < 3; p++) begin
            off = (p == 0) ? -90 : ((p == 1) ? 0 : 90);
            for (int i = 0; i < 250; i++) begin
                x = off + int'($urandom_range(0, 100)) - 50;
                if (x > 127) x = 127;
                if (x < -128) x = -128;
                if ($urandom_range(0, 149) == 0) begin
                    rst = 1'b1;
                    step(1'b1, x, 1'b1, 1'b1);
                    rst = 1'b0;
                end else begin
                    step(($urandom_range(0, 9) < 7), x,
                         ($urandom_range(0, 29) != 0), ($urandom_range(0, 3) != 0));
                end
            end
        end

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
